cexe_mem_stage: RTL
===================

Name: cexe_mem_stage

Overview:
Execute-to-Memory boundary of the 5-stage RV32I pipeline. It consumes the E-stage control signals produced by the D->E control register, plus ALU results and flags. It resolves branches and jumps (PCSrcE) combinationally and registers the E->M control and data bundle. It also keeps saturating branch/jump statistics counters. It supports a data-memory stall (hold) and a bubble flush.

Parameters:
XLEN, 32, datapath width
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-high
StallM  input  1  hold M register (data memory not ready)
FlushM  input  1  load bubble into M register
RegWriteE  input  1  register write enable (E)
ResultSrcE  input  2  result source select (E)
MemWriteE  input  1  memory write enable (E)
JumpE  input  1  jump instruction (E)
BranchE  input  1  conditional branch (E)
funct3E  input  3  branch condition / load-store size
ZeroE  input  1  ALU zero flag (A-B)
NegE  input  1  ALU negative flag
CarryE  input  1  ALU carry-out (1 = no borrow)
OvfE  input  1  ALU signed overflow
ALUResultE  input  XLEN  ALU result
WriteDataE  input  XLEN  forwarded rs2 store data
RdE  input  5  destination register
PCPlus4E  input  XLEN  PC+4 of E instruction
PCSrcE  output  1  redirect fetch (combinational)
RegWriteM  output  1  registered
ResultSrcM  output  2  registered
MemWriteM  output  1  registered
funct3M  output  3  registered
ALUResultM  output  XLEN  registered
WriteDataM  output  XLEN  registered
RdM  output  5  registered
PCPlus4M  output  XLEN  registered
BranchCnt  output  CNT_W  executed branches+jumps
TakenCnt  output  CNT_W  taken branches+jumps

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high (reset); all state updates occur on posedge clk only.
- Reset: all registered outputs are 0 on the first posedge with reset=1. Reset has priority over FlushM and StallM.
- Branch condition cond, combinational, from funct3E:
  - 000 BEQ: ZeroE
  - 001 BNE: !ZeroE
  - 100 BLT: NegE^OvfE
  - 101 BGE: !(NegE^OvfE)
  - 110 BLTU: !CarryE
  - 111 BGEU: CarryE
  - 010/011: 0
- PCSrcE = JumpE | (BranchE & cond). It is purely combinational and is not gated by StallM. The hazard unit is responsible for using it consistently.
- M register priority per posedge: reset > FlushM > StallM > load.
  - FlushM: RegWriteM=0, MemWriteM=0, ResultSrcM=00, RdM=0. Data fields are don't-care; implement as cleared to 0.
  - StallM (and no FlushM): every M output holds its value.
  - Otherwise: every M output takes its E counterpart. Latency is 1 cycle.
- Counters update on posedge when !reset & !StallM & (BranchE|JumpE):
  - BranchCnt += 1.
  - TakenCnt += 1 if PCSrcE.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- While StallM=1 the E instruction is held, so counters must not count it again. Each instruction is counted exactly once, on the cycle it advances.
- FlushM does not inhibit counting.
- Bubbles from FlushE upstream arrive with BranchE=JumpE=0 and are never counted.
- Counters reset to 0 on reset only.
- A store held under StallM keeps MemWriteM=1. The memory side commits it once, when the stall releases.

Test Plan:
- Reset with all E inputs high → next posedge: all M outputs 0, BranchCnt=TakenCnt=0, no MemWriteM pulse.
- Load path: ALUResultE=0x1000_0004, RdE=5, RegWriteE=1, ResultSrcE=01 → after 1 posedge ALUResultM=0x1000_0004, RdM=5, RegWriteM=1, ResultSrcM=01.
- Branch sweep: BranchE=1 with each funct3 against flag combos. Example: BLT with NegE=1, OvfE=0 → PCSrcE=1. BGEU with CarryE=0 → PCSrcE=0. funct3=010 → 0. After 8 advancing branches, BranchCnt=8 and TakenCnt equals the number of taken cases.
- Stall: MemWriteE=1, WriteDataE=0xDEAD_BEEF, then StallM=1 for 3 cycles with E changing → M holds 0xDEAD_BEEF and MemWriteM=1. A held branch during the stall increments BranchCnt only once.
- Flush vs. stall: FlushM=1 and StallM=1 together → RegWriteM=MemWriteM=0. Reset asserted alongside a valid branch → counters stay 0.
- Saturation (CNT_W=4): 20 taken jumps → BranchCnt=TakenCnt=15, no wrap.

Source files
------------

// File: rtl/cexe_mem_if.sv
// E-stage control/data bundle into the E->M boundary and the registered M-stage bundle out of it.
// The slave side is the pipeline register; the master side is whoever drives E and consumes M.
interface cexe_mem_if #(
  parameter int XLEN = 32
);
  logic            RegWriteE;
  logic [1:0]      ResultSrcE;
  logic            MemWriteE;
  logic            JumpE;
  logic            BranchE;
  logic [2:0]      funct3E;
  logic            ZeroE;
  logic            NegE;
  logic            CarryE;
  logic            OvfE;
  logic [XLEN-1:0] ALUResultE;
  logic [XLEN-1:0] WriteDataE;
  logic [4:0]      RdE;
  logic [XLEN-1:0] PCPlus4E;

  logic            PCSrcE;
  logic            RegWriteM;
  logic [1:0]      ResultSrcM;
  logic            MemWriteM;
  logic [2:0]      funct3M;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [4:0]      RdM;
  logic [XLEN-1:0] PCPlus4M;

  modport master (
    output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, funct3E,
    output ZeroE, NegE, CarryE, OvfE, ALUResultE, WriteDataE, RdE, PCPlus4E,
    input  PCSrcE, RegWriteM, ResultSrcM, MemWriteM, funct3M,
    input  ALUResultM, WriteDataM, RdM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, funct3E,
    input  ZeroE, NegE, CarryE, OvfE, ALUResultE, WriteDataE, RdE, PCPlus4E,
    output PCSrcE, RegWriteM, ResultSrcM, MemWriteM, funct3M,
    output ALUResultM, WriteDataM, RdM, PCPlus4M
  );
endinterface

// File: rtl/cexe_mem_stage.sv
// E->M pipeline register with combinational branch resolution (PCSrcE) and 1-cycle M latency.
// StallM holds the M bundle and freezes counting; FlushM loads a bubble; counters saturate.
module cexe_mem_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallM,
  input  logic             FlushM,
  cexe_mem_if.slave        bus,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] TakenCnt
);

  typedef struct packed {
    logic            regWrite;
    logic [1:0]      resultSrc;
    logic            memWrite;
    logic [2:0]      funct3;
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] writeData;
    logic [4:0]      rd;
    logic [XLEN-1:0] pcPlus4;
  } mBundle_t;

  mBundle_t eBundle;
  mBundle_t mBundle;
  logic     cond;
  logic     pcSrc;
  logic     isCtrl;
  logic     advance;

  always_comb begin
    cond = 1'b0;
    case (bus.funct3E)
      3'b000:  cond = bus.ZeroE;
      3'b001:  cond = !bus.ZeroE;
      3'b100:  cond = bus.NegE ^ bus.OvfE;
      3'b101:  cond = !(bus.NegE ^ bus.OvfE);
      3'b110:  cond = !bus.CarryE;
      3'b111:  cond = bus.CarryE;
      default: cond = 1'b0;
    endcase
  end

  // Redirect is not gated by StallM; the hazard unit qualifies it.
  assign pcSrc      = bus.JumpE | (bus.BranchE & cond);
  assign bus.PCSrcE = pcSrc;
  assign isCtrl     = bus.BranchE | bus.JumpE;
  assign advance    = !StallM;

  assign eBundle = '{
    regWrite:  bus.RegWriteE,
    resultSrc: bus.ResultSrcE,
    memWrite:  bus.MemWriteE,
    funct3:    bus.funct3E,
    aluResult: bus.ALUResultE,
    writeData: bus.WriteDataE,
    rd:        bus.RdE,
    pcPlus4:   bus.PCPlus4E
  };

  always_ff @(posedge clk) begin
    if (reset) begin
      mBundle <= '0;
    end else if (FlushM) begin
      mBundle <= '0;
    end else if (advance) begin
      mBundle <= eBundle;
    end
  end

  // Count only on the cycle the instruction leaves E, so a held instruction is counted once.
  always_ff @(posedge clk) begin
    if (reset) begin
      BranchCnt <= '0;
      TakenCnt  <= '0;
    end else if (advance && isCtrl) begin
      if (BranchCnt != {CNT_W{1'b1}}) begin
        BranchCnt <= BranchCnt + CNT_W'(1);
      end
      if (pcSrc && (TakenCnt != {CNT_W{1'b1}})) begin
        TakenCnt <= TakenCnt + CNT_W'(1);
      end
    end
  end

  assign bus.RegWriteM  = mBundle.regWrite;
  assign bus.ResultSrcM = mBundle.resultSrc;
  assign bus.MemWriteM  = mBundle.memWrite;
  assign bus.funct3M    = mBundle.funct3;
  assign bus.ALUResultM = mBundle.aluResult;
  assign bus.WriteDataM = mBundle.writeData;
  assign bus.RdM        = mBundle.rd;
  assign bus.PCPlus4M   = mBundle.pcPlus4;

endmodule
